// File: rtl/ysyx_22050039_mem_arbiter_pkg.sv
// ysyx_22050039_mem_arbiter_pkg: arbiter state encoding, master IDs and default widths
package ysyx_22050039_mem_arbiter_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;
  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;
endpackage

// File: rtl/ysyx_22050039_arb_pick.sv
// ysyx_22050039_arb_pick: two-master winner select, round-robin on ties or
// always LSU on ties when YSYX_22050039_ARB_FIXED_PRIO_EN is defined
module ysyx_22050039_arb_pick
  import ysyx_22050039_mem_arbiter_pkg::*;
(
  input  logic       v0,
  input  logic       v1,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       winner
);
`ifdef YSYX_22050039_ARB_FIXED_PRIO_EN
  assign winner = v1 ? M_LSU : M_IFU;
`else
  assign winner = (v0 && v1) ? ~last_grant : (v1 ? M_LSU : M_IFU);
`endif
  assign grant = {v1 && winner == M_LSU, v0 && winner == M_IFU};
endmodule

// File: rtl/ysyx_22050039_mem_arbiter.sv
// ysyx_22050039_mem_arbiter: shares one memory port between IFU (m0) and LSU (m1),
// one transaction outstanding; YSYX_22050039_ARB_FIXED_PRIO_EN selects fixed LSU priority
module ysyx_22050039_mem_arbiter
  import ysyx_22050039_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req_valid,
  output logic                m0_req_ready,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m0_wen,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  output logic                m0_resp_valid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req_valid,
  output logic                m1_req_ready,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_wen,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  output logic                m1_resp_valid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_req_valid,
  input  logic                s_req_ready,
  output logic [ADDR_W-1:0]   s_addr,
  output logic                s_wen,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wmask,
  input  logic                s_resp_valid,
  input  logic [DATA_W-1:0]   s_rdata
);
  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic [1:0]          grant;
  logic                winner;
  logic                done;

  ysyx_22050039_arb_pick u_pick (
    .v0         (m0_req_valid),
    .v1         (m1_req_valid),
    .last_grant (last_q),
    .grant      (grant),
    .winner     (winner)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    case (state_q)
      ST_IDLE: if (|grant) begin
        state_d = ST_REQ;
        owner_d = winner;
        addr_d  = winner ? m1_addr : m0_addr;
        wen_d   = winner ? m1_wen : m0_wen;
        wdata_d = winner ? m1_wdata : m0_wdata;
        wmask_d = winner ? m1_wmask : m0_wmask;
      end
      ST_REQ:  state_d = s_req_ready ? ST_WAIT : ST_REQ;
      ST_WAIT: if (s_resp_valid) begin
        state_d = ST_IDLE;
        last_d  = owner_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= M_IFU;
      last_q  <= M_LSU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  // ready is gated by rst_n so a held request cannot show an accept during reset
  assign m0_req_ready  = rst_n && state_q == ST_IDLE && grant[0];
  assign m1_req_ready  = rst_n && state_q == ST_IDLE && grant[1];
  assign done          = state_q == ST_WAIT && s_resp_valid;
  assign m0_resp_valid = done && owner_q == M_IFU;
  assign m1_resp_valid = done && owner_q == M_LSU;
  assign m0_rdata      = m0_resp_valid ? s_rdata : '0;
  assign m1_rdata      = m1_resp_valid ? s_rdata : '0;
  assign s_req_valid   = state_q == ST_REQ;
  assign s_addr        = addr_q;
  assign s_wen         = wen_q;
  assign s_wdata       = wdata_q;
  assign s_wmask       = wmask_q;
endmodule

// File: tb/tb_ysyx_22050039_mem_arbiter.sv
// tb_ysyx_22050039_mem_arbiter: scoreboard bench for the two-master memory arbiter
module tb_ysyx_22050039_mem_arbiter;
`ifdef YSYX_22050039_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  localparam logic [31:0] A0 = 32'h8000_0000;
  localparam logic [31:0] A1 = 32'h8000_1040;

  typedef struct packed {
    logic        id;
    logic        clean;
    logic [63:0] data;
  } rsp_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        m0_req_valid = 1'b0, m0_wen = 1'b0, m1_req_valid = 1'b0, m1_wen = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic [63:0] m0_wdata = '0, m1_wdata = '0;
  logic [7:0]  m0_wmask = '0, m1_wmask = '0;
  logic        s_req_ready = 1'b0, s_resp_valid = 1'b0;
  logic        m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid;
  logic [63:0] m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic        s_req_valid, s_wen;
  logic [31:0] s_addr;
  logic [7:0]  s_wmask;

  rsp_t exp_q[$];
  rsp_t obs_q[$];
  logic grant_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_f(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 64'h1234 : {~a, a};
  endfunction

  assign s_rdata = mem_f(s_addr);

  ysyx_22050039_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_resp_valid(m0_resp_valid), .m0_rdata(m0_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
    .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_resp_valid(m1_resp_valid), .m1_rdata(m1_rdata),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
    .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_resp_valid(s_resp_valid), .s_rdata(s_rdata)
  );

  // response monitor: records who answered and whether the idle side stayed silent
  always @(negedge clk)
    if (m0_resp_valid || m1_resp_valid)
      obs_q.push_back({m1_resp_valid,
                       !(m0_resp_valid && m1_resp_valid) && (m1_resp_valid ? m0_rdata == '0 : m1_rdata == '0),
                       m1_resp_valid ? m1_rdata : m0_rdata});

  task automatic do_reset();
    rst_n = 1'b0;
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic step(input int limit, input bit sticky);
    logic a0, a1;
    @(negedge clk);
    a0 = m0_req_ready;
    a1 = m1_req_ready;
    if (a0) grant_q.push_back(1'b0);
    if (a1) grant_q.push_back(1'b1);
    @(posedge clk);
    #1;
    if (grant_q.size() >= limit) begin
      m0_req_valid = 1'b0;
      m1_req_valid = 1'b0;
    end else if (!sticky) begin
      if (a0) m0_req_valid = 1'b0;
      if (a1) m1_req_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 30 && obs_q.size() < exp_q.size(); i++) begin
      @(negedge clk);
      #1;
    end
    n_chk++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s drain: got %0d responses, want %0d", name, obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_req_ready = 1'b1;
    s_resp_valid = 1'b1;
    m0_req_valid = 1'b1; m0_addr = A0;
    m1_req_valid = 1'b1; m1_addr = A1;
    #3;
    n_chk++;
    if ({m0_req_ready, m1_req_ready, s_req_valid, m0_resp_valid, m1_resp_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, want 00000",
               {m0_req_ready, m1_req_ready, s_req_valid, m0_resp_valid, m1_resp_valid});
    end
    n_chk++;
    if ({s_addr, s_wen, s_wdata, s_wmask, m0_rdata, m1_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: s_addr=%h s_wen=%b s_wdata=%h s_wmask=%h, want all 0",
               s_addr, s_wen, s_wdata, s_wmask);
    end
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({m0_req_ready, m1_req_ready, s_req_valid} !== 3'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got %b, want 000", {m0_req_ready, m1_req_ready, s_req_valid});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    m0_req_valid = 1'b1; m0_addr = A0; m0_wen = 1'b0;
    exp_q.push_back({1'b0, 1'b1, 64'h1234});
    @(negedge clk);
    n_chk++;
    if ({m0_req_ready, m1_req_ready, s_req_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL lat_accept: got %b, want 100", {m0_req_ready, m1_req_ready, s_req_valid});
    end
    @(posedge clk);
    #1 m0_req_valid = 1'b0;
    m0_addr = 32'hBAD0_0000;
    @(negedge clk);
    n_chk++;
    if ({s_req_valid, m0_req_ready, m0_resp_valid, s_addr} !== {3'b100, A0}) begin
      n_fail++;
      $display("FAIL lat_sreq: got valid=%b ready=%b resp=%b addr=%h, want 1 0 0 %h",
               s_req_valid, m0_req_ready, m0_resp_valid, s_addr, A0);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_chk++;
    if ({m0_resp_valid, m1_resp_valid, m0_rdata, m1_rdata} !== {2'b10, 64'h1234, 64'h0}) begin
      n_fail++;
      $display("FAIL lat_resp: got v0=%b v1=%b r0=%h r1=%h, want 1 0 1234 0",
               m0_resp_valid, m1_resp_valid, m0_rdata, m1_rdata);
    end
    @(posedge clk);
    #1;
    wait_drain("latency");
  endtask

  task automatic test_tie();
    logic want0;
    do_reset();
    grant_q.delete();
    want0 = FIXED ? 1'b1 : 1'b0;
    m0_addr = A0; m0_wen = 1'b0;
    m1_addr = A1; m1_wen = 1'b0;
    m0_req_valid = 1'b1;
    m1_req_valid = 1'b1;
    exp_q.push_back({want0, 1'b1, mem_f(want0 ? A1 : A0)});
    exp_q.push_back({~want0, 1'b1, mem_f(want0 ? A0 : A1)});
    for (int i = 0; i < 20 && grant_q.size() < 2; i++) step(2, 1'b0);
    n_chk++;
    if (grant_q.size() !== 2) begin
      n_fail++;
      $display("FAIL tie_count: got %0d grants, want 2", grant_q.size());
    end
    for (int i = 0; i < grant_q.size(); i++) begin
      n_chk++;
      if (grant_q[i] !== (i == 0 ? want0 : ~want0)) begin
        n_fail++;
        $display("FAIL tie_order[%0d]: got m%0d, want m%0d", i, grant_q[i], i == 0 ? want0 : ~want0);
      end
    end
    wait_drain("tie");
  endtask

  task automatic test_back_to_back();
    do_reset();
    grant_q.delete();
    m0_addr = A0;
    m1_addr = A1;
    m0_req_valid = 1'b1;
    m1_req_valid = 1'b1;
    for (int i = 0; i < 4; i++)
      exp_q.push_back({FIXED | i[0], 1'b1, mem_f((FIXED | i[0]) ? A1 : A0)});
    for (int i = 0; i < 40 && grant_q.size() < 4; i++) step(4, 1'b1);
    n_chk++;
    if (grant_q.size() !== 4) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d grants, want 4", grant_q.size());
    end
    for (int i = 0; i < grant_q.size(); i++) begin
      n_chk++;
      if (grant_q[i] !== (FIXED | i[0])) begin
        n_fail++;
        $display("FAIL b2b_grant[%0d]: got m%0d, want m%0d", i, grant_q[i], FIXED | i[0]);
      end
    end
    wait_drain("b2b");
  endtask

  task automatic test_stall();
    do_reset();
    s_req_ready = 1'b0;
    s_resp_valid = 1'b1;
    m1_req_valid = 1'b1; m1_addr = A1; m1_wen = 1'b1;
    m1_wdata = 64'hDEAD_BEEF; m1_wmask = 8'h0F;
    exp_q.push_back({1'b1, 1'b1, mem_f(A1)});
    @(negedge clk);
    n_chk++;
    if ({m0_req_ready, m1_req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL stall_accept: got %b, want 01", {m0_req_ready, m1_req_ready});
    end
    @(posedge clk);
    #1 m1_req_valid = 1'b0;
    m1_addr = '0; m1_wen = 1'b0; m1_wdata = '1; m1_wmask = 8'hFF;
    m0_req_valid = 1'b1; m0_addr = A0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if ({s_req_valid, s_addr, s_wen, s_wdata, s_wmask, m0_req_ready, m0_resp_valid, m1_resp_valid}
          !== {1'b1, A1, 1'b1, 64'hDEAD_BEEF, 8'h0F, 3'b000}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b a=%h w=%b d=%h m=%h r0=%b, want 1 %h 1 deadbeef 0f 0",
                 i, s_req_valid, s_addr, s_wen, s_wdata, s_wmask, m0_req_ready, A1);
      end
      @(posedge clk);
      #1;
    end
    m0_req_valid = 1'b0;
    s_req_ready = 1'b1;
    wait_drain("stall");
  endtask

  task automatic test_reset_mid();
    int n0;
    do_reset();
    s_req_ready = 1'b1;
    s_resp_valid = 1'b0;
    m0_req_valid = 1'b1; m0_addr = A0; m0_wen = 1'b0;
    @(posedge clk);
    #1 m0_req_valid = 1'b0;
    @(posedge clk);
    #1 n0 = obs_q.size();
    rst_n = 1'b0;
    s_resp_valid = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({m0_req_ready, m1_req_ready, s_req_valid, m0_resp_valid, m1_resp_valid, s_addr, s_wen, s_wdata, s_wmask,
         m0_rdata, m1_rdata} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outs: got rv0=%b rv1=%b sv=%b a=%h, want all 0",
               m0_resp_valid, m1_resp_valid, s_req_valid, s_addr);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({s_req_valid, m0_resp_valid, m1_resp_valid} !== 3'b0 || obs_q.size() !== n0) begin
      n_fail++;
      $display("FAIL rstmid_silent: got sv=%b rv=%b%b responses=%0d, want 0 00 %0d",
               s_req_valid, m0_resp_valid, m1_resp_valid, obs_q.size(), n0);
    end
    @(posedge clk);
    #1 m0_req_valid = 1'b1;
    exp_q.push_back({1'b0, 1'b1, mem_f(A0)});
    @(negedge clk);
    n_chk++;
    if (m0_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_idle: got m0_req_ready=%b, want 1", m0_req_ready);
    end
    @(posedge clk);
    #1 m0_req_valid = 1'b0;
    wait_drain("rstmid");
  endtask

  task automatic test_idle_resp();
    int n0;
    do_reset();
    s_req_ready = 1'b1;
    s_resp_valid = 1'b1;
    n0 = obs_q.size();
    @(negedge clk);
    n_chk++;
    if ({m0_resp_valid, m1_resp_valid, s_req_valid} !== 3'b0 || obs_q.size() !== n0) begin
      n_fail++;
      $display("FAIL idle_resp: got rv=%b%b sv=%b, want 000", m0_resp_valid, m1_resp_valid, s_req_valid);
    end
    @(posedge clk);
    #1 s_resp_valid = 1'b0;
    m1_req_valid = 1'b1; m1_addr = A1; m1_wen = 1'b0;
    exp_q.push_back({1'b1, 1'b1, mem_f(A1)});
    @(negedge clk);
    n_chk++;
    if ({m0_req_ready, m1_req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL idle_state: got %b, want 01", {m0_req_ready, m1_req_ready});
    end
    @(posedge clk);
    #1 m1_req_valid = 1'b0;
    s_resp_valid = 1'b1;
    wait_drain("idle");
  endtask

  task automatic test_scoreboard();
    rsp_t e, o;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL sb_resp: got id=%0d clean=%b data=%h, want id=%0d clean=1 data=%h",
                 o.id, o.clean, o.data, e.id, e.data);
      end
    end
    n_chk++;
    if (exp_q.size() + obs_q.size() !== 0) begin
      n_fail++;
      $display("FAIL sb_left: got %0d unmatched, want 0", exp_q.size() + obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_tie();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_idle_resp();
    test_scoreboard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end
endmodule
